// File: rtl/ffsr_pkg.sv
// Shared definitions for the FFSR pulse encoder/decoder pair: decoder state
// encoding and the output-width helpers both sides size their ports with.
package ffsr_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} ffsr_dec_state_t;

    // Bits needed to hold a count of 0..n ones.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to hold an index 0..n-1.
    function automatic int pos_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ffsr_pulse_decode.sv
// Serial FFSR pulse decoder: scans a latched code one bit per clock from index 0
// and reports run width, leading-one index and a non-contiguous-run flag.
module ffsr_pulse_decode
    import ffsr_pkg::*;
#(
    parameter int INPUT_SIZE = 16,
    localparam int CNT_W = cnt_w(INPUT_SIZE),
    localparam int POS_W = pos_w(INPUT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:INPUT_SIZE-1] code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      width,
    output logic [POS_W-1:0]      pos,
    output logic                  err
);

    ffsr_dec_state_t       state;
    logic [0:INPUT_SIZE-1] sr;
    logic [CNT_W-1:0]      cnt;
    logic [POS_W-1:0]      pos_acc;
    logic [POS_W-1:0]      idx;
    logic                  seen;
    logic                  ended;
    logic                  err_acc;

    logic                  bit_cur;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [POS_W-1:0]      pos_nxt;
    logic                  seen_nxt;
    logic                  ended_nxt;
    logic                  err_nxt;
    logic                  last_bit;

    // Accumulator updates for the bit consumed this cycle; also feed the
    // result registers on the final scan edge so the last bit is included.
    always_comb begin
        bit_cur   = sr[0];
        cnt_nxt   = bit_cur ? cnt + CNT_W'(1) : cnt;
        pos_nxt   = (bit_cur && !seen) ? idx : pos_acc;
        seen_nxt  = seen | bit_cur;
        ended_nxt = ended | (!bit_cur && seen);
        err_nxt   = err_acc | (bit_cur && ended);
        last_bit  = (idx == POS_W'(INPUT_SIZE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            width     <= '0;
            pos       <= '0;
            err       <= 1'b0;
            sr        <= '0;
            cnt       <= '0;
            pos_acc   <= '0;
            idx       <= '0;
            seen      <= 1'b0;
            ended     <= 1'b0;
            err_acc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= code;
                        cnt      <= '0;
                        pos_acc  <= '0;
                        idx      <= '0;
                        seen     <= 1'b0;
                        ended    <= 1'b0;
                        err_acc  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    sr      <= sr << 1;
                    cnt     <= cnt_nxt;
                    pos_acc <= pos_nxt;
                    seen    <= seen_nxt;
                    ended   <= ended_nxt;
                    err_acc <= err_nxt;
                    if (last_bit) begin
                        width     <= cnt_nxt;
                        pos       <= pos_nxt;
                        err       <= err_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + POS_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
